downcnt_timer: RTL and testbench

DOWNCNT_TIMER -- requirements
Module: downcnt_timer

---
 rtl/downcnt_timer.sv | 112 +++++++++++
 tb/tb_downcnt_timer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/downcnt_timer.sv
// Loadable down-counter timer with IDLE/RUN/DONE control and a one-cycle terminal-count pulse.
// Define DOWNCNT_AUTORELOAD_EN to reload from the reload register at terminal count (periodic mode).
module downcnt_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             tc_q, tc_d;

    // State register; reset overrides every other request.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            tc_q    <= tc_d;
        end
    end

    // Next-state and datapath; load wins over start, start over en.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        tc_d    = 1'b0;
        if (load) begin
            q_d     = d;
            r_d     = d;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (q_q != '0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DONE;
                            tc_d    = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // A zero count never decrements, so q cannot wrap.
                    if (en && (q_q != '0)) begin
                        if (q_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
`ifdef DOWNCNT_AUTORELOAD_EN
                            if (r_q != '0) begin
                                q_d = r_q;
                            end else begin
                                q_d     = '0;
                                state_d = ST_DONE;
                            end
`else
                            q_d     = '0;
                            state_d = ST_DONE;
`endif
                        end else begin
                            q_d = q_q - WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        q_d = r_q;
                        if (r_q != '0) begin
                            state_d = ST_RUN;
                        end else begin
                            tc_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        q    = q_q;
        tc   = tc_q;
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_downcnt_timer.sv
// Self-checking bench for downcnt_timer: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model (honours DOWNCNT_AUTORELOAD_EN).
module tb_downcnt_timer;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             nrst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             tc;

    int n_cmp = 0;
    int n_err = 0;

    typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_q    = 0;
    int    m_r    = 0;
    int    m_tc   = 0;

    downcnt_timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .en    (en),
        .load  (load),
        .d     (d),
        .start (start),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .tc    (tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: one clock edge worth of the timer's rules.
    task automatic model_step();
        m_tc = 0;
        if (!nrst) begin
            m_q = 0; m_r = 0; m_mode = M_IDLE;
        end else if (load) begin
            m_q = int'(d); m_r = int'(d); m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    if (m_q == 0) begin m_mode = M_DONE; m_tc = 1; end
                    else m_mode = M_RUN;
                end
                M_RUN: if (en && m_q > 0) begin
                    m_q = m_q - 1;
                    if (m_q == 0) begin
                        m_tc = 1;
`ifdef DOWNCNT_AUTORELOAD_EN
                        if (m_r > 0) m_q = m_r;
                        else m_mode = M_DONE;
`else
                        m_mode = M_DONE;
`endif
                    end
                end
                default: if (start) begin
                    m_q = m_r;
                    if (m_r == 0) m_tc = 1;
                    else m_mode = M_RUN;
                end
            endcase
        end
    endtask

    // Advance one edge, update the model, then compare away from the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("mdl_q",    32'(q),    32'(m_q));
        chk("mdl_busy", 32'(busy), 32'(m_mode == M_RUN));
        chk("mdl_done", 32'(done), 32'(m_mode == M_DONE));
        chk("mdl_tc",   32'(tc),   32'(m_tc));
    endtask

    task automatic idle_inputs();
        load = 1'b0; start = 1'b0; en = 1'b0;
    endtask

    initial begin
        int tcs;
        int runs;
        int exp_seq[4];

        nrst = 1'b0; load = 1'b0; start = 1'b0; en = 1'b0; d = '0;
        #2;

        // Reset with a pending load that must be ignored.
        load = 1'b1; d = 4'd5;
        tick(); tick();
        chk("rst_q", 32'(q), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tc", 32'(tc), 0);
        nrst = 1'b1; idle_inputs();

        // One-shot count from 3; load is honoured on the first cycle after reset.
        load = 1'b1; d = 4'd3; tick();
        chk("os_load_q", 32'(q), 3);
        load = 1'b0; start = 1'b1; tick();
        chk("os_start_q", 32'(q), 3);
        chk("os_start_busy", 32'(busy), 1);
        start = 1'b0; en = 1'b1;
        exp_seq = '{2, 1, 0, 0};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("os_q", 32'(q), 32'(exp_seq[i]));
            chk("os_tc", 32'(tc), 32'(i == 2));
        end
        chk("os_done", 32'(done), 1);
        chk("os_busy", 32'(busy), 0);
        tick();
        chk("os_tc_width", 32'(tc), 0);
        chk("os_hold_q", 32'(q), 0);
        idle_inputs();

        // Enable gaps: q holds at 1 for two cycles, tc once, four RUN cycles.
        load = 1'b1; d = 4'd2; tick();
        load = 1'b0; start = 1'b1; tick();
        start = 1'b0;
        tcs = 0; runs = int'(busy);
        exp_seq = '{1, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            en = (i == 0 || i == 3);
            tick();
            chk("gap_q", 32'(q), 32'(exp_seq[i]));
            tcs += int'(tc); runs += int'(busy);
        end
        en = 1'b0; tick(); tcs += int'(tc);
        chk("gap_tc_count", 32'(tcs), 1);
        chk("gap_run_cycles", 32'(runs), 4);

        // Restart from DONE reloads from the reload register.
        start = 1'b1; tick();
        chk("restart_q", 32'(q), 2);
        chk("restart_busy", 32'(busy), 1);
        idle_inputs();

        // Zero load then start: straight to DONE with one tc.
        load = 1'b1; d = 4'd0; tick();
        load = 1'b0; start = 1'b1; tick();
        chk("zero_done", 32'(done), 1);
        chk("zero_tc", 32'(tc), 1);
        start = 1'b0; tick();
        chk("zero_tc_off", 32'(tc), 0);

        // Load and start together: load only.
        load = 1'b1; start = 1'b1; d = 4'd15; tick();
        chk("ls_q", 32'(q), 15);
        chk("ls_busy", 32'(busy), 0);
        chk("ls_done", 32'(done), 0);
        idle_inputs();

        // Reset mid-run at q=6.
        load = 1'b1; d = 4'd8; tick();
        load = 1'b0; start = 1'b1; tick();
        start = 1'b0; en = 1'b1; tick(); tick();
        chk("abort_pre_q", 32'(q), 6);
        nrst = 1'b0; tick();
        chk("abort_q", 32'(q), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_tc", 32'(tc), 0);
        nrst = 1'b1; idle_inputs();

        // Load mid-run at q=4.
        load = 1'b1; d = 4'd7; tick();
        load = 1'b0; start = 1'b1; tick();
        start = 1'b0; en = 1'b1; tick(); tick(); tick();
        chk("midload_pre_q", 32'(q), 4);
        load = 1'b1; d = 4'd9; tick();
        chk("midload_q", 32'(q), 9);
        chk("midload_busy", 32'(busy), 0);
        chk("midload_tc", 32'(tc), 0);
        idle_inputs();

        // Periodic vs one-shot terminal behaviour with d=2.
        load = 1'b1; d = 4'd2; tick();
        load = 1'b0; start = 1'b1; tick();
        start = 1'b0; en = 1'b1; tcs = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tcs += int'(tc);
`ifdef DOWNCNT_AUTORELOAD_EN
            chk("ar_q", 32'(q), 32'((i % 2 == 0) ? 1 : 2));
            chk("ar_tc", 32'(tc), 32'(i % 2 == 1));
            chk("ar_busy", 32'(busy), 1);
`else
            chk("os8_done", 32'(done), 32'(i >= 1));
`endif
        end
`ifdef DOWNCNT_AUTORELOAD_EN
        chk("ar_tc_count", 32'(tcs), 4);
`else
        chk("os8_tc_count", 32'(tcs), 1);
`endif
        idle_inputs();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            nrst  = ($urandom_range(0, 59) != 0);
            load  = ($urandom_range(0, 14) == 0);
            start = ($urandom_range(0, 5) == 0);
            en    = ($urandom_range(0, 3) != 0);
            d     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2))
                                                : 4'($urandom_range(0, 15));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
